imm_extend_pipe: RTL

IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

---
 rtl/imm_extend_pipe.sv | 130 +++++++++++++
 1 files changed

// File: rtl/imm_extend_pipe.sv
// Two-stage immediate extender with a valid/ready handshake on both sides.
// S1 extends, shifts and flags overflow; S2 adds the branch base and drives the output.
module imm_extend_pipe #(
    parameter int IN_W  = 24,
    parameter int OUT_W = 32,
    parameter int SHIFT = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  imm_in,
    input  logic [1:0]       mode,
    input  logic [OUT_W-1:0] pc_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] data_out,
    output logic             ovf
);

    typedef enum logic [1:0] {
        MODE_ZEXT   = 2'b00,
        MODE_SEXT   = 2'b01,
        MODE_SHIFT  = 2'b10,
        MODE_BRANCH = 2'b11
    } mode_t;

    logic [OUT_W+IN_W-1:0] sext_wide;
    logic [OUT_W+IN_W-1:0] zext_wide;
    logic [OUT_W-1:0]      sext;
    logic [OUT_W-1:0]      zext;
    logic [OUT_W-1:0]      shifted;
    logic                  shift_ovf;

    logic [OUT_W-1:0]      s1_next_value;
    logic                  s1_next_ovf;
    logic                  s1_next_branch;

    logic                  s1_valid;
    logic [OUT_W-1:0]      s1_value;
    logic                  s1_ovf;
    logic                  s1_branch;
    logic [OUT_W-1:0]      s1_pc;

    logic                  s2_valid;
    logic [OUT_W-1:0]      s2_data;
    logic                  s2_ovf;

    logic                  s2_free;

    assign sext_wide = {{OUT_W{imm_in[IN_W-1]}}, imm_in};
    assign zext_wide = {{OUT_W{1'b0}}, imm_in};
    assign sext      = sext_wide[OUT_W-1:0];
    assign zext      = zext_wide[OUT_W-1:0];
    assign shifted   = sext << SHIFT;

    // Every bit shifted out, plus the new sign bit, must match the original sign.
    always_comb begin
        shift_ovf = 1'b0;
        for (int i = OUT_W - 1 - SHIFT; i < OUT_W - 1; i++) begin
            if (sext[i] != sext[OUT_W-1]) begin
                shift_ovf = 1'b1;
            end
        end
    end

    always_comb begin
        s1_next_value  = zext;
        s1_next_ovf    = 1'b0;
        s1_next_branch = 1'b0;
        case (mode_t'(mode))
            MODE_ZEXT: begin
                s1_next_value = zext;
            end
            MODE_SEXT: begin
                s1_next_value = sext;
            end
            MODE_SHIFT: begin
                s1_next_value = shifted;
                s1_next_ovf   = shift_ovf;
            end
            MODE_BRANCH: begin
                s1_next_value  = shifted;
                s1_next_ovf    = shift_ovf;
                s1_next_branch = 1'b1;
            end
            default: begin
                s1_next_value = zext;
            end
        endcase
    end

    // A stage may load whenever the slot after it is empty or draining this cycle.
    assign s2_free  = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_value  <= '0;
            s1_ovf    <= 1'b0;
            s1_branch <= 1'b0;
            s1_pc     <= '0;
        end else if (in_ready) begin
            s1_valid  <= in_valid;
            s1_value  <= s1_next_value;
            s1_ovf    <= s1_next_ovf;
            s1_branch <= s1_next_branch;
            s1_pc     <= pc_in;
        end
    end

    // The branch base is the fetch address plus 8, wrapping at OUT_W bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_ovf   <= 1'b0;
        end else if (s2_free) begin
            s2_valid <= s1_valid;
            s2_data  <= s1_branch ? (s1_pc + OUT_W'(8) + s1_value) : s1_value;
            s2_ovf   <= s1_ovf;
        end
    end

    assign out_valid = s2_valid;
    assign data_out  = s2_valid ? s2_data : '0;
    assign ovf       = s2_valid ? s2_ovf : 1'b0;

endmodule
